alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares the single 8-bit ALU between up to four requesters (e.g., execute stage, address generator, compare unit, debug port). It accepts one operation at a time over a valid/ready handshake, latches the operands, drives the ALU for one cycle, and captures the result and status flags into a registered response tagged with the requester ID. The ALU itself stays combinational and sits beside this block; the arbiter owns all ALU inputs.

## Interface
- NUM_REQ, 4, number of requesters (2..4); the ID width is fixed at 2 bits
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  per-requester operation valid
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_operand_a  input  8*NUM_REQ  operand A; requester i uses bits [8i+7:8i]
- req_operand_b  input  8*NUM_REQ  operand B, packed the same way as req_operand_a
- req_alu_op  input  4*NUM_REQ  ALU opcode; requester i uses bits [4i+3:4i]
- alu_operand_a  output  8  to ALU operand_a (registered)
- alu_operand_b  output  8  to ALU operand_b (registered)
- alu_op  output  4  to ALU alu_op (registered)
- alu_result  input  8  from ALU result
- alu_zero, alu_carry, alu_overflow, alu_negative  input  1 each  ALU flags
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept
- rsp_id  output  2  index of the requester that issued the operation
- rsp_result  output  8  captured ALU result
- rsp_flags  output  4  {negative, overflow, carry, zero}
- rsp_err  output  1  opcode was 4'hE or 4'hF, which the ALU does not define
- busy  output  1  state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- Arbitration is round-robin. The search starts at rr_ptr and walks upward modulo NUM_REQ. The first requester with req_valid high wins.
- Grant window: req_ready[winner] is driven combinationally high only in IDLE, or in RESP when rsp_ready=1. A grant always means the handshake completes in that cycle.
- On accept:
  - Latch the winner's operand A, operand B and opcode into the alu_* registers.
  - Latch the winner index into the ID register.
  - Set rr_ptr to (winner+1) mod NUM_REQ.
  - Move to EXEC.
- EXEC:
  - The ALU settles on the latched inputs.
  - At the clock edge, capture alu_result and the four flags into the rsp_* registers.
  - Set rsp_err to (alu_op ≥ 4'hE).
  - Move to RESP.
- RESP:
  - rsp_valid=1. All rsp_* outputs hold stable until rsp_ready=1.
  - rsp_ready=1 with a winner present: accept the new request and go to EXEC. rsp_valid drops for one cycle.
  - rsp_ready=1 with no requester: go to IDLE.
  - rsp_ready=0: stay in RESP with no grants.
- The alu_* registers keep their last value outside EXEC. No ALU output is sampled except at the EXEC→RESP edge.
- Undefined opcodes (4'hE, 4'hF) are still issued. The response carries whatever the ALU returns (result 0, flags as computed) plus rsp_err=1.
- Requester bits at index ≥ NUM_REQ do not exist. rr_ptr wraps at NUM_REQ-1 → 0.

## Timing
- Reset values (asynchronous): state=IDLE, rr_ptr=0, alu_operand_a=0, alu_operand_b=0, alu_op=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, rsp_err=0, busy=0, req_ready=0.
- Latency: an accept in cycle N gives rsp_valid=1 in cycle N+2.
- Throughput: one operation per 2 cycles when rsp_ready is held high.
- Requests arriving together: exactly one grant per cycle. A requester that stays valid is served within NUM_REQ operations (no starvation).
- A requester may drop req_valid before it is granted; no state changes.
- If rst asserts mid-operation, the in-flight operation and any pending response are discarded. Outputs return to reset values immediately, without waiting for a clock edge.
- req_ready depends combinationally on req_valid, rsp_ready and state. It does not depend on ALU outputs, so there is no combinational loop through the ALU.

## Test plan
- Single op: requester 0 sends ADD 8'h7F+8'h01 → rsp_valid 2 cycles after accept; rsp_id=0, rsp_result=8'h80, rsp_flags=4'b1100 (N=1, V=1, C=0, Z=0), rsp_err=0.
- Contention: all four requesters hold valid with SUB 5-5, ADD FF+01, AND, XOR, rsp_ready=1 → grant order 0,1,2,3,0…; the ID-1 response has result 8'h00, flags Z=1, C=1; issue rate is 1 per 2 cycles.
- Backpressure: response pending and rsp_ready=0 for 5 cycles with requester 2 valid → no req_ready, rsp_* stable; when rsp_ready=1, requester 2 is granted in the same cycle and its response follows 2 cycles later.
- Undefined opcode: requester 3 sends alu_op=4'hF → rsp_result=8'h00, rsp_flags Z=1, rsp_err=1.
- Round-robin wrap: rr_ptr=3 and requesters 1 and 3 valid → grant 3, then 1; rr_ptr then reads 2.
- Reset mid-op: assert rst while in EXEC → rsp_valid=0, busy=0 and all alu_* outputs 0 without a clock edge; after release, the first request completes normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer sharing one combinational 8-bit ALU
// among up to four requesters, returning a registered, ID-tagged response.
module alu_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_operand_a,
  input  logic [8*NUM_REQ-1:0] req_operand_b,
  input  logic [4*NUM_REQ-1:0] req_alu_op,
  output logic [7:0]           alu_operand_a,
  output logic [7:0]           alu_operand_b,
  output logic [3:0]           alu_op,
  input  logic [7:0]           alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_carry,
  input  logic                 alu_overflow,
  input  logic                 alu_negative,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [7:0]           rsp_result,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] rr_ptr;
  logic [1:0] op_id;
  logic [1:0] win_id;
  logic       win_found;
  logic       grant_open;
  logic       accept;

  // (base + k) mod NUM_REQ without a divider
  function automatic logic [1:0] rr_idx(
    input logic [1:0] base,
    input int         k
  );
    logic [2:0] s;
    s = {1'b0, base} + 3'(k);
    if (s >= 3'(NUM_REQ))
      s = s - 3'(NUM_REQ);
    return s[1:0];
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[rr_idx(rr_ptr, k)]) begin
        win_found = 1'b1;
        win_id    = rr_idx(rr_ptr, k);
      end
    end
  end

  assign accept = grant_open && win_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready)
          state_nxt = accept ? EXEC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grants never look at ALU outputs, so no loop closes through the ALU
  always_comb begin
    grant_open = 1'b0;
    busy       = (state != IDLE);
    rsp_valid  = (state == RESP);
    unique case (state)
      IDLE:    grant_open = !rst;
      RESP:    grant_open = !rst && rsp_ready;
      default: grant_open = 1'b0;
    endcase
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = accept && (win_id == 2'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      op_id         <= '0;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
      alu_op        <= '0;
    end else if (accept) begin
      rr_ptr        <= rr_idx(win_id, 1);
      op_id         <= win_id;
      alu_operand_a <= req_operand_a[{win_id, 3'b000} +: 8];
      alu_operand_b <= req_operand_b[{win_id, 3'b000} +: 8];
      alu_op        <= req_alu_op[{win_id, 2'b00} +: 4];
    end
  end

  // ALU outputs are sampled only on the EXEC to RESP edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id     <= op_id;
      rsp_result <= alu_result;
      rsp_flags  <= {alu_negative, alu_overflow,
                     alu_carry, alu_zero};
      rsp_err    <= (alu_op >= 4'hE);
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with a behavioural ALU and
// a round-robin reference model driven by directed and random traffic.
module tb_alu_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_operand_a = '0;
  logic [8*N-1:0] req_operand_b = '0;
  logic [4*N-1:0] req_alu_op = '0;
  logic [7:0]     alu_operand_a;
  logic [7:0]     alu_operand_b;
  logic [3:0]     alu_op;
  logic [7:0]     alu_result;
  logic           alu_zero;
  logic           alu_carry;
  logic           alu_overflow;
  logic           alu_negative;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic [7:0]     rsp_result;
  logic [3:0]     rsp_flags;
  logic           rsp_err;
  logic           busy;
  logic [11:0]    alu_out;

  typedef struct {
    logic [1:0] id;
    logic [7:0] res;
    logic [3:0] flags;
    logic       err;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t log_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic in_rst = 1'b1;

  int         m_ptr = 0;
  logic       m_busy = 1'b0;
  int         m_acc = 0;
  logic [7:0] m_a, m_b;
  logic [3:0] m_op;

  logic        held = 1'b0;
  logic [14:0] hv;

  int g_id[8];
  int g_cyc[8];

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operand_a(req_operand_a),
    .req_operand_b(req_operand_b),
    .req_alu_op(req_alu_op),
    .alu_operand_a(alu_operand_a),
    .alu_operand_b(alu_operand_b),
    .alu_op(alu_op),
    .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow),
    .alu_negative(alu_negative),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {N,V,C,Z,result}; 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA, E/F undefined
  function automatic logic [11:0] alu_ref(
    input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0] w;
    logic [7:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; r = '0;
    case (op)
      4'h0: begin
        w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'h1: begin
        w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = ~w[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a << b[2:0];
      4'h6: r = a >> b[2:0];
      4'h7: r = $signed(a) >>> b[2:0];
      4'hE, 4'hF: r = '0;
      default: r = ~a;
    endcase
    return {r[7], v, c, (r == 8'h00), r};
  endfunction

  assign alu_out      = alu_ref(alu_operand_a, alu_operand_b, alu_op);
  assign alu_result   = alu_out[7:0];
  assign alu_zero     = alu_out[8];
  assign alu_carry    = alu_out[9];
  assign alu_overflow = alu_out[10];
  assign alu_negative = alu_out[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: who should be granted, and what the answer must be
  always @(negedge clk) begin : model
    logic hs;
    int w;
    logic [N-1:0] exp_rdy;
    exp_t e;
    if (!in_rst) begin
      hs = m_busy && (cyc - m_acc >= 2) && rsp_ready;
      chk("busy", busy, m_busy);
      chk("rsp_valid", rsp_valid, m_busy && (cyc - m_acc >= 2));
      if (m_busy && (cyc - m_acc == 1))
        chk("alu_inputs", {alu_operand_a, alu_operand_b, alu_op},
            {m_a, m_b, m_op});
      w = -1;
      if (!m_busy || hs)
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      if (hs) m_busy = 1'b0;
      if (w >= 0) begin
        m_a  = req_operand_a[8*w +: 8];
        m_b  = req_operand_b[8*w +: 8];
        m_op = req_alu_op[4*w +: 4];
        e.id = 2'(w);
        {e.flags, e.res} = alu_ref(m_a, m_b, m_op);
        e.err = (m_op >= 4'hE);
        e.acc = cyc;
        sb.push_back(e);
        m_ptr  = (w + 1) % N;
        m_busy = 1'b1;
        m_acc  = cyc;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    exp_t r;
    if (!in_rst) begin
      if (rsp_valid) begin
        if (!held) begin
          chk("rsp_pending", sb.size() != 0, 1);
          if (sb.size() != 0) chk("rsp_latency", cyc - sb[0].acc, 2);
          held = 1'b1;
          hv = {rsp_id, rsp_result, rsp_flags, rsp_err};
        end else begin
          chk("rsp_stable", {rsp_id, rsp_result, rsp_flags, rsp_err}, hv);
        end
        if (rsp_ready) begin
          held = 1'b0;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_result", rsp_result, e.res);
            chk("rsp_flags", rsp_flags, e.flags);
            chk("rsp_err", rsp_err, e.err);
            r.id = rsp_id; r.res = rsp_result;
            r.flags = rsp_flags; r.err = rsp_err; r.acc = cyc;
            log_q.push_back(r);
          end
        end
      end else begin
        chk("rsp_dropped", held, 0);
      end
    end
  end

  task automatic clear_model();
    sb.delete();
    m_busy = 1'b0;
    m_ptr = 0;
    held = 1'b0;
  endtask

  task automatic do_reset();
    in_rst = 1'b1;
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    clear_model();
    rst = 1'b0;
    in_rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] op);
    req_operand_a[8*i +: 8] = a;
    req_operand_b[8*i +: 8] = b;
    req_alu_op[4*i +: 4] = op;
  endtask

  task automatic issue(input int i, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] op);
    int t = 0;
    set_req(i, a, b, op);
    req_valid[i] = 1'b1;
    do begin
      @(negedge clk); t++;
    end while (!req_ready[i] && t < 40);
    chk($sformatf("grant_req%0d", i), req_ready[i], 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    rsp_ready = 1'b1;
    while ((busy || sb.size() != 0) && t < 60) begin
      @(negedge clk); t++;
    end
    chk("drain", busy || (sb.size() != 0), 0);
    @(posedge clk); #1;
  endtask

  task automatic grant_seq(input logic [N-1:0] mask, input int n);
    int got = 0;
    int t = 0;
    req_valid = mask;
    while (got < n && t < 60) begin
      @(negedge clk); t++;
      for (int i = 0; i < N; i++)
        if (req_ready[i] && got < n) begin
          g_id[got] = i; g_cyc[got] = cyc; got++;
        end
    end
    chk("grant_count", got, n);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  initial begin
    int t;
    #1 rst = 1'b1;
    #2;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_alu_in", {alu_operand_a, alu_operand_b, alu_op}, 0);
    chk("rst_rsp", {rsp_id, rsp_result, rsp_flags, rsp_err}, 0);
    do_reset();

    // single op
    rsp_ready = 1'b1;
    log_q.delete();
    issue(0, 8'h7F, 8'h01, 4'h0);
    drain();
    chk("single_n", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("single_id", log_q[0].id, 0);
      chk("single_res", log_q[0].res, 8'h80);
      chk("single_flags", log_q[0].flags, 4'b1100);
      chk("single_err", log_q[0].err, 0);
    end

    // contention
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 8'h05, 8'h05, 4'h1);
    set_req(1, 8'hFF, 8'h01, 4'h0);
    set_req(2, 8'hC6, 8'h5A, 4'h2);
    set_req(3, 8'h3C, 8'h0F, 4'h4);
    log_q.delete();
    grant_seq(4'hF, 8);
    drain();
    for (int k = 0; k < 8; k++) chk("cont_order", g_id[k], k % 4);
    for (int k = 1; k < 8; k++) chk("cont_rate", g_cyc[k] - g_cyc[k-1], 2);
    chk("cont_n", log_q.size(), 8);
    if (log_q.size() >= 2) begin
      chk("cont_id1", log_q[1].id, 1);
      chk("cont_res1", log_q[1].res, 8'h00);
      chk("cont_zc1", log_q[1].flags[1:0], 2'b11);
      chk("cont_z0", log_q[0].flags[0], 1);
    end

    // backpressure
    do_reset();
    rsp_ready = 1'b0;
    log_q.delete();
    issue(0, 8'h10, 8'h20, 4'h0);
    t = 0;
    do begin
      @(negedge clk); t++;
    end while (!rsp_valid && t < 10);
    chk("bp_rsp_seen", rsp_valid, 1);
    @(posedge clk); #1;
    set_req(2, 8'h81, 8'h03, 4'h6);
    req_valid[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_no_grant", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    drain();
    chk("bp_n", log_q.size(), 2);
    if (log_q.size() >= 2) chk("bp_id", log_q[1].id, 2);

    // undefined opcode
    log_q.delete();
    issue(3, 8'h5A, 8'hC3, 4'hF);
    drain();
    chk("undef_n", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("undef_res", log_q[0].res, 8'h00);
      chk("undef_z", log_q[0].flags[0], 1);
      chk("undef_err", log_q[0].err, 1);
    end

    // round-robin wrap
    do_reset();
    issue(2, 8'h01, 8'h02, 4'h3);
    drain();
    set_req(1, 8'h11, 8'h22, 4'h0);
    set_req(3, 8'h33, 8'h44, 4'h1);
    grant_seq(4'b1010, 2);
    drain();
    chk("wrap_first", g_id[0], 3);
    chk("wrap_second", g_id[1], 1);
    set_req(0, 8'h55, 8'h66, 4'h5);
    set_req(2, 8'h77, 8'h88, 4'h7);
    grant_seq(4'b0101, 1);
    drain();
    chk("wrap_ptr2", g_id[0], 2);

    // reset while in EXEC
    do_reset();
    issue(1, 8'h12, 8'h34, 4'h0);
    #1;
    in_rst = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_alu_in", {alu_operand_a, alu_operand_b, alu_op}, 0);
    @(posedge clk); #1;
    clear_model();
    rst = 1'b0;
    in_rst = 1'b0;
    log_q.delete();
    issue(1, 8'h12, 8'h34, 4'h0);
    drain();
    chk("mid_after_n", log_q.size(), 1);
    if (log_q.size() >= 1) chk("mid_after_res", log_q[0].res, 8'h46);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      req_operand_a = $urandom;
      req_operand_b = $urandom;
      req_alu_op = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = '0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
